// File: rtl/dnn_output_evaluator_if.sv
// Signal bundle between the DNN output-layer stream and the evaluator.
// The master drives the per-neuron stream; the slave (the evaluator) drives the results.
interface dnn_output_evaluator_if #(
  parameter int width     = 32,
  parameter int cpc       = 18,
  parameter int window    = 100,
  parameter int cnt_width = 32
);
  localparam int idxWidth    = $clog2(cpc);
  localparam int errWidth    = width + $clog2(cpc - 2) + 1;
  localparam int recentWidth = $clog2(window + 1);

  logic [idxWidth-1:0]    cycle_index;
  logic                   a_out;
  logic                   y_out;
  logic [width-1:0]       act;
  logic                   case_done;
  logic                   case_correct;
  logic                   case_error;
  logic [errWidth-1:0]    case_abs_err;
  logic [cnt_width-1:0]   num_cases;
  logic [cnt_width-1:0]   total_error;
  logic [recentWidth-1:0] recent_correct;

  modport master (
    output cycle_index, a_out, y_out, act,
    input  case_done, case_correct, case_error, case_abs_err,
           num_cases, total_error, recent_correct
  );

  modport slave (
    input  cycle_index, a_out, y_out, act,
    output case_done, case_correct, case_error, case_abs_err,
           num_cases, total_error, recent_correct
  );
endinterface

// File: rtl/dnn_output_evaluator.sv
// Scores each training case from the DNN output stream and keeps running
// totals plus a sliding count of correct cases over the last `window` cases.
module dnn_output_evaluator #(
  parameter int width     = 32,
  parameter int frac_bits = 21,
  parameter int cpc       = 18,
  parameter int window    = 100,
  parameter int cnt_width = 32
) (
  input logic clk,
  input logic reset,
  dnn_output_evaluator_if.slave eval_if
);
  localparam int idxWidth    = $clog2(cpc);
  localparam int errWidth    = width + $clog2(cpc - 2) + 1;
  localparam int recentWidth = $clog2(window + 1);

  localparam logic [idxWidth-1:0] firstSample = idxWidth'(2);
  localparam logic [idxWidth-1:0] lastIdx     = idxWidth'(cpc - 1);

  localparam logic signed [width:0] halfVal =
    {{(width + 1 - frac_bits){1'b0}}, 1'b1, {(frac_bits - 1){1'b0}}};
  localparam logic signed [width:0] oneVal =
    {{(width - frac_bits){1'b0}}, 1'b1, {frac_bits{1'b0}}};
  localparam logic signed [width:0] zeroVal = '0;

  logic                   armed_q, armed_d;
  logic                   wrongAcc_q, wrongAcc_d;
  logic                   mismAcc_q, mismAcc_d;
  logic [errWidth-1:0]    errAcc_q, errAcc_d;
  logic                   caseDone_q, caseDone_d;
  logic                   caseCorrect_q, caseCorrect_d;
  logic                   caseError_q, caseError_d;
  logic [errWidth-1:0]    caseAbsErr_q, caseAbsErr_d;
  logic [cnt_width-1:0]   numCases_q, numCases_d;
  logic [cnt_width-1:0]   totalError_q, totalError_d;
  logic [window-1:0]      window_q, window_d;
  logic [recentWidth-1:0] recent_q, recent_d;

  logic signed [width:0] actExt;
  logic signed [width:0] target;
  logic signed [width:0] diff;
  logic [width:0]        absErr;
  logic                  wrongK;
  logic                  mismK;
  logic                  isSample;
  logic                  isFinal;

  // One extra bit keeps act minus the target from overflowing before the magnitude is taken.
  assign actExt   = {eval_if.act[width-1], eval_if.act};
  assign target   = eval_if.y_out ? oneVal : zeroVal;
  assign diff     = actExt - target;
  assign absErr   = diff[width] ? -diff : diff;
  assign wrongK   = ((actExt > halfVal) && !eval_if.y_out) ||
                    ((actExt < halfVal) && eval_if.y_out);
  assign mismK    = eval_if.a_out != eval_if.y_out;
  assign isSample = (eval_if.cycle_index >= firstSample) && (eval_if.cycle_index <= lastIdx);
  assign isFinal  = armed_q && (eval_if.cycle_index == lastIdx);

  always_comb begin
    armed_d       = armed_q;
    wrongAcc_d    = wrongAcc_q;
    mismAcc_d     = mismAcc_q;
    errAcc_d      = errAcc_q;
    caseDone_d    = 1'b0;
    caseCorrect_d = caseCorrect_q;
    caseError_d   = caseError_q;
    caseAbsErr_d  = caseAbsErr_q;
    numCases_d    = numCases_q;
    totalError_d  = totalError_q;
    window_d      = window_q;
    recent_d      = recent_q;

    if (eval_if.cycle_index == '0) begin
      armed_d    = 1'b1;
      wrongAcc_d = 1'b0;
      mismAcc_d  = 1'b0;
      errAcc_d   = '0;
    end else if (isFinal) begin
      // The last neuron is folded straight into the result rather than the accumulators.
      caseDone_d    = 1'b1;
      caseCorrect_d = !(wrongAcc_q | wrongK);
      caseError_d   = mismAcc_q | mismK;
      caseAbsErr_d  = errAcc_q + errWidth'(absErr);
      if (numCases_q != '1) begin
        numCases_d = numCases_q + cnt_width'(1);
      end
      if (caseError_d && (totalError_q != '1)) begin
        totalError_d = totalError_q + cnt_width'(1);
      end
      window_d = {window_q[window-2:0], caseCorrect_d};
      recent_d = recent_q + recentWidth'(caseCorrect_d) - recentWidth'(window_q[window-1]);
    end else if (armed_q && isSample) begin
      wrongAcc_d = wrongAcc_q | wrongK;
      mismAcc_d  = mismAcc_q | mismK;
      errAcc_d   = errAcc_q + errWidth'(absErr);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      armed_q       <= 1'b0;
      wrongAcc_q    <= 1'b0;
      mismAcc_q     <= 1'b0;
      errAcc_q      <= '0;
      caseDone_q    <= 1'b0;
      caseCorrect_q <= 1'b0;
      caseError_q   <= 1'b0;
      caseAbsErr_q  <= '0;
      numCases_q    <= '0;
      totalError_q  <= '0;
      window_q      <= '0;
      recent_q      <= '0;
    end else begin
      armed_q       <= armed_d;
      wrongAcc_q    <= wrongAcc_d;
      mismAcc_q     <= mismAcc_d;
      errAcc_q      <= errAcc_d;
      caseDone_q    <= caseDone_d;
      caseCorrect_q <= caseCorrect_d;
      caseError_q   <= caseError_d;
      caseAbsErr_q  <= caseAbsErr_d;
      numCases_q    <= numCases_d;
      totalError_q  <= totalError_d;
      window_q      <= window_d;
      recent_q      <= recent_d;
    end
  end

  assign eval_if.case_done      = caseDone_q;
  assign eval_if.case_correct   = caseCorrect_q;
  assign eval_if.case_error     = caseError_q;
  assign eval_if.case_abs_err   = caseAbsErr_q;
  assign eval_if.num_cases      = numCases_q;
  assign eval_if.total_error    = totalError_q;
  assign eval_if.recent_correct = recent_q;
endmodule

// File: doc/dnn_output_evaluator.md
# dnn_output_evaluator

Hardware scoreboard that sits directly downstream of the DNN output layer. It consumes the one-output-neuron-per-clock stream (`a_out`, `y_out`, fixed-point activation `act`) aligned to the cycle block counter. For each training case it produces a correct/incorrect verdict, a hard-mismatch flag and an absolute-error sum. It also keeps running totals and a sliding count of correct results over the last `window` cases, so training accuracy is observable on-chip without a simulation-only monitor.

## Interface
- `width`, 32, activation word width (two's complement fixed point)
- `frac_bits`, 21, fractional bits of `act`
- `cpc`, 18, clocks per training case; `n_out = cpc-2` output neurons per case
- `window`, 100, sliding-window depth in cases
- `cnt_width`, 32, width of case/error counters

- `clk` in 1: single clock, all state on rising edge
- `reset` in 1: asynchronous, active-low; clears all state
- `cycle_index` in `$clog2(cpc)`: position within case, from cycle block counter
- `a_out` in 1: thresholded DNN output bit for neuron `cycle_index-2`
- `y_out` in 1: ideal output bit for the same neuron
- `act` in `width`: signed fixed-point activation for the same neuron
- `case_done` out 1: one-cycle pulse, case results valid
- `case_correct` out 1: last case classified correctly
- `case_error` out 1: last case had any `a_out != y_out`
- `case_abs_err` out `width+$clog2(n_out)+1`: sum over neurons of |act − y|, unsigned
- `num_cases` out `cnt_width`: evaluated cases, saturating
- `total_error` out `cnt_width`: cases with `case_error`, saturating
- `recent_correct` out `$clog2(window+1)`: correct cases among the last min(num_cases, window)

## Operation
- Sample cycles: `cycle_index` in 2..cpc-1; neuron k = `cycle_index-2`. Cycles 0 and 1 are ignored.
- Arming: after reset the block is disarmed. It arms on the first edge with `cycle_index==0`. Samples are accumulated only while armed, so a partial case is never scored.
- Per sample, with half = 1<<(frac_bits−1) and one = 1<<frac_bits, and `act` signed:
  - wrong_k = (act > half && !y_out) || (act < half && y_out). act == half is never wrong.
  - mismatch_k = (a_out != y_out).
  - err_k = |act − (y_out ? one : 0)|, computed in width+1 bits signed, then absolute value.
- Accumulators: `wrong_acc` (OR), `mism_acc` (OR), `err_acc` (sum). They are cleared when `cycle_index==0`.
- Finalize on the edge sampling `cycle_index==cpc-1` while armed; the last sample is folded in on that edge:
  - `case_correct <= !(wrong_acc|wrong_k)`.
  - `case_error <= mism_acc|mismatch_k`.
  - `case_abs_err <= err_acc+err_k`.
  - `num_cases` increments, holding at all-ones.
  - `total_error` increments if `case_error`, holding at all-ones.
  - The window shift register (`window` bits, reset 0) shifts in `case_correct`.
  - `recent_correct <= recent_correct + new − oldest_bit_shifted_out`. Pre-fill bits are 0, so no special case is needed before `window` cases.
- Simultaneous events: finalize and accumulator clear never coincide (different `cycle_index`). If reset is asserted it wins over everything.
- Reset mid-case discards the partial case, and the block re-arms at the next `cycle_index==0`.

## Timing
- Reset values: every output is 0, the window register is 0, and the block is disarmed.
- Latency: results are registered on the edge where `cycle_index==cpc-1` is sampled. `case_done` is high for exactly the following clock, which is the clock in which `cycle_index==0`.
- Result outputs hold until the next finalize.
- Throughput: one case per `cpc` clocks, with no stall or backpressure.
- Inputs are sampled on the same edge the DNN presents them; there is no input pipelining.

## Test plan
- Reset: hold `reset=0` for 5 clocks with random inputs -> all outputs 0, no `case_done`. Release at `cycle_index=9` -> no `case_done` until one full case after the first `cycle_index==0`.
- Perfect case: y one-hot at k=3, act=one (0x00200000) at k=3 and 0 elsewhere, a_out==y_out -> `case_done` pulse at `cycle_index==0`, with `case_correct=1`, `case_error=0`, `case_abs_err=0`, `num_cases=1`, `recent_correct=1`.
- Threshold boundary, case A: act=0x00100000 (exactly 0.5) with y=1 -> `case_correct=1`, `case_abs_err=0x00100000`.
- Threshold boundary, case B: act=0x00100001 with y=0 -> `case_correct=0`.
- Negative activation: act=−0.25 (0xFFF80000) at the y=1 neuron, others exact -> `case_correct=0`, `case_abs_err=2621440` (1.25·2^21). With a_out=1 there, also `case_error=1` and `total_error=1`.
- Sliding window: 150 back-to-back cases, cases 1–120 correct and 121–150 wrong -> `recent_correct` reaches 100 at case 100, stays 100 through case 120, and ends at 70 after case 150. `num_cases=150`.
